if_stage_s: RTL and testbench
=============================

IF_STAGE_S -- requirements
Module: if_stage_s

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013: addi x0,x0,0, inserted on bubbles and flushes.
REQ-003 clk  in  1  sole clock, all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 stall  in  1  from hazard detection, freezes PC and IF/ID register.
REQ-006 redirect  in  1  taken branch or jal/jalr resolved downstream.
REQ-007 redirect_pc  in  32  target address, valid when redirect=1.
REQ-008 imem_req  out  1  instruction-memory request.
REQ-009 imem_addr  out  32  fetch address, held stable while imem_req=1.
REQ-010 imem_valid  in  1  memory response, same cycle as or later than the request.
REQ-011 imem_rdata  in  32  instruction word, sampled only when imem_req=1 and imem_valid=1.
REQ-012 ifid_instruction  out  32  IF/ID register instruction, consumed by the decode stage.
REQ-013 ifid_pc  out  32  address of ifid_instruction.
REQ-014 ifid_valid  out  1  1 = real instruction, 0 = bubble.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, HOLD, DROP.
REQ-016 IDLE: imem_req=0; SHALL go to FETCH on the next cycle.
REQ-017 FETCH: imem_req=1, imem_addr=pc.
REQ-018 A fetch SHALL complete in any cycle with imem_req=1 and imem_valid=1; zero-wait and multi-wait memories SHALL both be supported.
REQ-019 FETCH with completion, no redirect, no stall:
- IF/ID <= {imem_rdata, pc, 1}.
- pc <= pc+4 (mod 2^32).
- Stay in FETCH, which gives throughput of 1 instruction/cycle.
REQ-020 FETCH with completion and stall:
- rdata captured into a one-entry buffer.
- IF/ID holds.
- Go to HOLD.
REQ-021 FETCH without completion, no stall: IF/ID <= {NOP_INSTR, ifid_pc unchanged, 0} (bubble).
REQ-022 FETCH without completion, with stall: IF/ID holds.
REQ-023 HOLD: imem_req=0; when stall=0, IF/ID <= {buffer, pc, 1}, pc <= pc+4, go to FETCH.
REQ-024 DROP: imem_req=1 at the abandoned address; on completion, discard data, pc <= pending_pc, go to FETCH.
REQ-025 Priority SHALL be rst > redirect > stall.
REQ-026 Redirect in any state SHALL flush IF/ID to {NOP_INSTR, ifid_pc, 0} that cycle, regardless of stall.
REQ-027 Redirect routing by state:
- Redirect in FETCH with completion, or in HOLD: data/buffer discarded, pc <= redirect_pc, go to FETCH.
- Redirect in FETCH without completion: pending_pc <= redirect_pc, go to DROP.
- Redirect in DROP: pending_pc <= redirect_pc, where the latest redirect wins, and completion that cycle uses the new target.
REQ-028 imem_addr SHALL NOT change while imem_req=1 and the fetch is incomplete.
REQ-029 Redirect targets SHALL be used unmodified, with no alignment check.

Reset
REQ-030 When rst=1 at a clock edge:
- pc=RESET_PC, pending_pc=RESET_PC, state=IDLE.
- imem_req=0, imem_addr=RESET_PC.
- ifid_instruction=NOP_INSTR, ifid_pc=0, ifid_valid=0; buffer cleared.
REQ-031 Reset mid-fetch SHALL abandon the outstanding request with no DROP; responses during reset SHALL be ignored.
REQ-032 The first imem_req=1 SHALL occur in the second cycle after rst deasserts.

Verification
REQ-033 Zero-wait memory, no hazards: rst released -> imem_addr 0,4,8,... on consecutive cycles; ifid_pc follows one cycle later with ifid_valid=1.
REQ-034 Two-wait-state memory at addr 0x10: ifid_valid=0 with NOP 0x00000013 for 2 cycles, then instruction at 0x10 valid; next addr 0x14.
REQ-035 stall high 3 cycles while fetch at 0x20 completes -> IF/ID frozen, imem_req=0 in HOLD, then 0x20 delivered and 0x24 requested the cycle after stall falls.
REQ-036 redirect to 0x100 while fetch at 0x40 waits: DROP entered, 0x40 data discarded, next request at 0x100, no valid instruction from 0x40.
REQ-037 redirect=1 and stall=1 same cycle (target 0x200): IF/ID flushed to NOP, ifid_valid=0, next fetch 0x200.
REQ-038 rst asserted during a pending fetch at 0x80 -> next requested address RESET_PC, stale imem_valid ignored.

Source files
------------

// File: rtl/if_stage_s.sv
// if_stage_s: RISC-V instruction-fetch stage with IF/ID pipeline register.
// Fetches one instruction per cycle from a variable-latency instruction
// memory. It supports stalls from hazard detection, redirects from
// branches and jumps, and the draining of abandoned fetches.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   stall             freeze PC and IF/ID (hazard detection)
//   redirect          taken branch / jump resolved downstream
//   redirect_pc       redirect target, used as-is
//   imem_req          instruction-memory request
//   imem_addr         fetch address, stable while a request is outstanding
//   imem_valid        memory response for the current request
//   imem_rdata        instruction word returned by memory
//   ifid_instruction  IF/ID instruction (NOP on bubbles and flushes)
//   ifid_pc           address of ifid_instruction
//   ifid_valid        1 = real instruction, 0 = bubble
module if_stage_s #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instruction,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pending_pc;
    logic [31:0] buffer;
    logic        done;
    logic [31:0] drop_target;

    // PC is only updated when no request is outstanding or the request
    // completes. This keeps the fetch address stable and allows it to be
    // driven straight from the PC register.
    assign imem_addr   = pc;
    assign done        = imem_req && imem_valid;
    // In DROP, a redirect arriving in the completion cycle takes precedence.
    assign drop_target = redirect ? redirect_pc : pending_pc;

    // Fetch FSM, PC and IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            pc               <= RESET_PC;
            pending_pc       <= RESET_PC;
            buffer           <= 32'h0;
            imem_req         <= 1'b0;
            ifid_instruction <= NOP_INSTR;
            ifid_pc          <= 32'h0;
            ifid_valid       <= 1'b0;
        end else begin
            // A redirect flushes IF/ID in every state, whether or not stall is set.
            if (redirect) begin
                ifid_instruction <= NOP_INSTR;
                ifid_valid       <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end

                FETCH: begin
                    if (redirect) begin
                        if (done) begin
                            pc <= redirect_pc;
                        end else begin
                            // The outstanding request must still drain.
                            pending_pc <= redirect_pc;
                            state      <= DROP;
                        end
                    end else if (done) begin
                        if (stall) begin
                            buffer   <= imem_rdata;
                            state    <= HOLD;
                            imem_req <= 1'b0;
                        end else begin
                            ifid_instruction <= imem_rdata;
                            ifid_pc          <= pc;
                            ifid_valid       <= 1'b1;
                            pc               <= pc + 32'd4;
                        end
                    end else if (!stall) begin
                        ifid_instruction <= NOP_INSTR;
                        ifid_valid       <= 1'b0;
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        pc       <= redirect_pc;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end else if (!stall) begin
                        ifid_instruction <= buffer;
                        ifid_pc          <= pc;
                        ifid_valid       <= 1'b1;
                        pc               <= pc + 32'd4;
                        state            <= FETCH;
                        imem_req         <= 1'b1;
                    end
                end

                DROP: begin
                    if (redirect) begin
                        pending_pc <= redirect_pc;
                    end
                    if (done) begin
                        pc    <= drop_target;
                        state <= FETCH;
                    end
                end

                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage_s.sv
// tb_if_stage_s: directed testbench for if_stage_s with a responsive
// instruction memory. Wait states are programmable per phase, and a
// forced-valid override drives responses during reset.
module tb_if_stage_s;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pc;
    logic        ifid_valid;

    int n_cmp;
    int n_err;
    int waits;
    int wcnt;
    logic force_valid;

    if_stage_s dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_valid       (imem_valid),
        .imem_rdata       (imem_rdata),
        .ifid_instruction (ifid_instruction),
        .ifid_pc          (ifid_pc),
        .ifid_valid       (ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    // Memory model: responds once `waits` cycles of the request have elapsed.
    always_comb begin
        imem_rdata = instr_at(imem_addr);
        imem_valid = force_valid | (imem_req && (wcnt >= waits));
    end

    always @(posedge clk) begin
        if (rst)                      wcnt <= 0;
        else if (imem_req && imem_valid) wcnt <= 0;
        else if (imem_req)            wcnt <= wcnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ifid(input string tag, input logic [31:0] ins,
                               input logic [31:0] pcv, input logic v);
        check({tag, ".instr"}, ifid_instruction, ins);
        check({tag, ".pc"}, ifid_pc, pcv);
        check({tag, ".valid"}, 32'(ifid_valid), 32'(v));
    endtask

    task automatic expect_req(input string tag, input logic r, input logic [31:0] a);
        check({tag, ".req"}, 32'(imem_req), 32'(r));
        check({tag, ".addr"}, imem_addr, a);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        waits = 0; force_valid = 1'b0;

        step(); step();
        expect_req("reset", 1'b0, 32'h0);
        expect_ifid("reset", NOP, 32'h0, 1'b0);

        // Zero-wait streaming from RESET_PC.
        rst = 1'b0;
        step();
        expect_req("first_req", 1'b1, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            expect_req("stream", 1'b1, 32'(4 * (k + 1)));
            expect_ifid("stream", instr_at(32'(4 * k)), 32'(4 * k), 1'b1);
        end

        // Two wait states at 0x10.
        waits = 2;
        step();
        expect_req("wait1", 1'b1, 32'h10);
        expect_ifid("wait1", NOP, 32'hC, 1'b0);
        step();
        expect_req("wait2", 1'b1, 32'h10);
        expect_ifid("wait2", NOP, 32'hC, 1'b0);
        step();
        expect_req("wait_done", 1'b1, 32'h14);
        expect_ifid("wait_done", instr_at(32'h10), 32'h10, 1'b1);

        waits = 0;
        step(); step(); step();
        expect_req("pre_stall", 1'b1, 32'h20);
        expect_ifid("pre_stall", instr_at(32'h1C), 32'h1C, 1'b1);

        // Stall for 3 cycles while the fetch at 0x20 completes.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold.req", 32'(imem_req), 32'h0);
            expect_ifid("hold", instr_at(32'h1C), 32'h1C, 1'b1);
        end
        stall = 1'b0;
        step();
        expect_req("release", 1'b1, 32'h24);
        expect_ifid("release", instr_at(32'h20), 32'h20, 1'b1);

        // Redirect to 0x40 while a fetch completes.
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        expect_req("redir_done", 1'b1, 32'h40);
        expect_ifid("redir_done", NOP, 32'h20, 1'b0);

        // Redirect to 0x100 while the fetch at 0x40 waits: DROP path.
        redirect = 1'b0; waits = 2;
        step();
        expect_ifid("wait40", NOP, 32'h20, 1'b0);
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        expect_req("drop", 1'b1, 32'h40);
        expect_ifid("drop", NOP, 32'h20, 1'b0);
        redirect = 1'b0;
        step();
        expect_req("drop_done", 1'b1, 32'h100);
        expect_ifid("drop_done", NOP, 32'h20, 1'b0);
        waits = 0;
        step();
        expect_req("after_drop", 1'b1, 32'h104);
        expect_ifid("after_drop", instr_at(32'h100), 32'h100, 1'b1);

        // Redirect and stall asserted together.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        step();
        expect_req("redir_stall", 1'b1, 32'h200);
        expect_ifid("redir_stall", NOP, 32'h100, 1'b0);
        stall = 1'b0; redirect = 1'b0;
        step();
        expect_ifid("at200", instr_at(32'h200), 32'h200, 1'b1);

        // Reset during a pending fetch at 0x80, with stale responses.
        redirect = 1'b1; redirect_pc = 32'h80;
        step();
        expect_req("to80", 1'b1, 32'h80);
        redirect = 1'b0; waits = 5;
        step();
        expect_req("pend80", 1'b1, 32'h80);
        rst = 1'b1; force_valid = 1'b1;
        step();
        expect_req("rst_mid", 1'b0, 32'h0);
        expect_ifid("rst_mid", NOP, 32'h0, 1'b0);
        step();
        expect_ifid("rst_stale", NOP, 32'h0, 1'b0);
        rst = 1'b0; force_valid = 1'b0; waits = 0;
        step();
        expect_req("rst_refetch", 1'b1, 32'h0);
        expect_ifid("rst_refetch", NOP, 32'h0, 1'b0);
        step();
        expect_req("rst_stream", 1'b1, 32'h4);
        expect_ifid("rst_stream", instr_at(32'h0), 32'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
